// File: rtl/conv2d_edge_mac_pipe.sv
// Pipelined multiply-accumulate for the edge-convolution datapath: one result per
// kernel window, post-processed (truncate / clip / abs-clip), valid/ready on both sides.
module conv2d_edge_mac_pipe #(
  parameter int DIN0_WIDTH  = 8,
  parameter int DIN1_WIDTH  = 10,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int NUM_STAGE   = 2,
  parameter int ACC_WIDTH   = 24,
  parameter int OUT_WIDTH   = 8,
  parameter int OUT_MODE    = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_ovf
);

  localparam int P  = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int SW = ((ACC_WIDTH > P) ? ACC_WIDTH : P) + 1;
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  logic                    advance;
  logic signed [P-1:0]     op0, op1, prod;
  logic [NUM_STAGE-1:0]    vld_q, vld_d;
  logic [NUM_STAGE-1:0]    first_q, last_q;
  logic signed [P-1:0]     prod_q [NUM_STAGE];
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                    ovf_win_q, ovf_win_d;
  logic signed [SW-1:0]    base, sum;
  logic signed [ACC_WIDTH:0] acc_x, mag;
  logic                    acc_en, res_en;
  logic                    out_valid_q, out_ovf_q;
  logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;

  // A stalled result blocks everything behind it, including the input.
  assign advance  = !(out_valid_q && !out_ready);
  assign in_ready = advance;

  // Extension to P bits keeps the product exact for every signedness mix.
  assign op0  = {{(P - DIN0_WIDTH){(DIN0_SIGNED != 0) && din0[DIN0_WIDTH-1]}}, din0};
  assign op1  = {{(P - DIN1_WIDTH){(DIN1_SIGNED != 0) && din1[DIN1_WIDTH-1]}}, din1};
  assign prod = op0 * op1;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    vld_d = vld_q;
    if (advance) begin
      vld_d[0] = in_valid;
      for (int i = 1; i < NUM_STAGE; i++) vld_d[i] = vld_q[i-1];
    end
  end

  // NOTE: the payload shift register has no reset; only the valid bits need one, which keeps it a plain register chain.
  always_ff @(posedge ap_clk) begin
    if (advance) begin
      prod_q[0]  <= prod;
      first_q[0] <= in_first;
      last_q[0]  <= in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i]  <= prod_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  always_comb begin
    acc_en     = advance && vld_q[NUM_STAGE-1];
    res_en     = acc_en && last_q[NUM_STAGE-1];
    base       = first_q[NUM_STAGE-1] ? '0
                 : {{(SW - ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
    sum        = base + {{(SW - P){prod_q[NUM_STAGE-1][P-1]}}, prod_q[NUM_STAGE-1]};
    acc_d      = acc_q;
    ovf_win_d  = ovf_win_q;
    if (acc_en) begin
      acc_d     = sum[ACC_WIDTH-1:0];
      // Representable iff all bits from the ACC sign bit upward agree.
      ovf_win_d = (!first_q[NUM_STAGE-1] && ovf_win_q)
                  || !((&sum[SW-1:ACC_WIDTH-1]) || !(|sum[SW-1:ACC_WIDTH-1]));
    end

    acc_x      = {acc_d[ACC_WIDTH-1], acc_d};
    mag        = ((OUT_MODE == 2) && acc_x[ACC_WIDTH]) ? -acc_x : acc_x;
    out_data_d = mag[OUT_WIDTH-1:0];
    if (OUT_MODE == 0)      out_data_d = acc_d[OUT_WIDTH-1:0];
    else if (mag[ACC_WIDTH]) out_data_d = '0;
    else if (mag > OUT_MAX)  out_data_d = '1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld_q       <= '0;
      acc_q       <= '0;
      ovf_win_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      acc_q     <= acc_d;
      ovf_win_q <= ovf_win_d;
      if (res_en) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_ovf_q   <= ovf_win_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_conv2d_edge_mac_pipe.sv
// Self-checking bench: five parameter variants share one input stream and are
// scored against a window-level arithmetic model.
module tb_conv2d_edge_mac_pipe;

  localparam int NCFG = 5;
  // Variants: default, truncate, abs-clip, 19-bit accumulator, signed pixel.
  localparam int C_S0   [NCFG] = '{0, 0, 0, 0, 1};
  localparam int C_S1   [NCFG] = '{1, 1, 1, 1, 1};
  localparam int C_ACC  [NCFG] = '{24, 24, 24, 19, 24};
  localparam int C_MODE [NCFG] = '{1, 0, 2, 1, 1};

  typedef struct packed {
    logic [NCFG-1:0][7:0] data;
    logic [NCFG-1:0]      ovf;
  } exp_t;

  logic       ap_clk = 1'b0;
  logic       ap_rst = 1'b1;
  logic       in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] din0 = '0;
  logic [9:0] din1 = '0;
  logic       ir [NCFG];
  logic       ov [NCFG];
  logic       oo [NCFG];
  logic [7:0] od [NCFG];

  always #5 ap_clk = ~ap_clk;

  conv2d_edge_mac_pipe u_def (.ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od[0]), .out_ovf(oo[0]));
  conv2d_edge_mac_pipe #(.OUT_MODE(0)) u_m0 (.ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid),
    .in_ready(ir[1]), .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ovf(oo[1]));
  conv2d_edge_mac_pipe #(.OUT_MODE(2)) u_m2 (.ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid),
    .in_ready(ir[2]), .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_ovf(oo[2]));
  conv2d_edge_mac_pipe #(.ACC_WIDTH(19)) u_a19 (.ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid),
    .in_ready(ir[3]), .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .out_ovf(oo[3]));
  conv2d_edge_mac_pipe #(.DIN0_SIGNED(1)) u_s1 (.ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid),
    .in_ready(ir[4]), .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(ov[4]), .out_ready(out_ready), .out_data(od[4]), .out_ovf(oo[4]));

  int      n_cmp = 0, n_fail = 0, n_fire = 0, cyc = 0;
  int      first_valid_cyc = -1, last_acc_cyc = 0;
  logic    hit = 1'b0, prev_valid = 1'b0, rand_rdy = 1'b0;
  logic    s_ready, s_valid, s_ovf;
  logic [7:0] s_data;
  logic [7:0] last_data [NCFG];
  logic       last_ovf  [NCFG];
  longint  m_acc [NCFG];
  logic    m_ovf [NCFG];
  exp_t    exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic longint sext(input longint v, input int w, input int s);
    if (s != 0 && v >= (longint'(1) << (w - 1))) return v - (longint'(1) << w);
    return v;
  endfunction

  function automatic logic [7:0] post(input longint r, input int mode);
    longint m;
    if (mode == 0) return 8'(r & 255);
    m = (mode == 2 && r < 0) ? -r : r;
    if (m < 0)   return 8'd0;
    if (m > 255) return 8'd255;
    return 8'(m);
  endfunction

  // Window arithmetic straight from the rules: exact sum, wrap, sticky overflow.
  task automatic model_beat(input logic [7:0] d0, input logic [9:0] d1, input logic f, input logic l);
    exp_t   e;
    longint p, s, lim, r;
    e = '0;
    for (int i = 0; i < NCFG; i++) begin
      p   = sext(longint'(d0), 8, C_S0[i]) * sext(longint'(d1), 10, C_S1[i]);
      s   = (f ? 0 : m_acc[i]) + p;
      lim = longint'(1) << (C_ACC[i] - 1);
      m_ovf[i] = (f ? 1'b0 : m_ovf[i]) | (s < -lim || s >= lim);
      r = s & ((longint'(1) << C_ACC[i]) - 1);
      if (r >= lim) r -= longint'(1) << C_ACC[i];
      m_acc[i]  = r;
      e.data[i] = post(r, C_MODE[i]);
      e.ovf[i]  = m_ovf[i];
    end
    if (l) exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  // One clock: sample at the falling edge, score, update the model, step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge ap_clk);
    s_ready = ir[0];
    s_valid = ov[0];
    s_data  = od[0];
    s_ovf   = oo[0];
    hit     = in_valid && ir[0] && !ap_rst;
    if (ov[0] && out_ready && !ap_rst) begin
      n_fire++;
      check("result_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NCFG; i++) begin
          check($sformatf("data_c%0d", i), 64'(od[i]), 64'(e.data[i]));
          check($sformatf("ovf_c%0d", i), 64'(oo[i]), 64'(e.ovf[i]));
          last_data[i] = od[i];
          last_ovf[i]  = oo[i];
        end
      end
    end
    if (ov[0] && !prev_valid) first_valid_cyc = cyc;
    prev_valid = ov[0];
    if (hit) begin
      model_beat(din0, din1, in_first, in_last);
      if (in_last) last_acc_cyc = cyc;
    end
    @(posedge ap_clk);
    #1;
    cyc++;
  endtask

  task automatic wait_accept();
    for (int k = 0; k < 200; k++) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (hit) break;
    end
    check("accept_timeout", 64'(hit), 64'd1);
  endtask

  task automatic send_beat(input logic [7:0] d0, input logic [9:0] d1, input logic f, input logic l);
    in_valid = 1'b1;
    din0     = d0;
    din1     = d1;
    in_first = f;
    in_last  = l;
    wait_accept();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
    check("valid_clears", 64'(s_valid), 64'd0);
  endtask

  task automatic send_lap(input logic [7:0] centre);
    for (int k = 0; k < 9; k++)
      send_beat((k == 4) ? centre : 8'd100, (k == 4) ? 10'd8 : 10'h3FF, k == 0, k == 8);
  endtask

  initial begin
    int f0, c0;
    model_reset();

    // Reset state: ready is high even while reset is held.
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_ready", 64'(s_ready), 64'd1);
      check("rst_valid", 64'(s_valid), 64'd0);
      check("rst_data",  64'(s_data),  64'd0);
      check("rst_ovf",   64'(s_ovf),   64'd0);
    end
    ap_rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(s_ready), 64'd1);

    // Laplacian on flat field, with latency measured from the last beat.
    first_valid_cyc = -1;
    send_lap(8'd100);
    drain();
    check("latency", 64'(first_valid_cyc - last_acc_cyc), 64'd3);
    check("lap_flat_m1", 64'(last_data[0]), 64'd0);
    check("lap_flat_m2", 64'(last_data[2]), 64'd0);

    send_lap(8'd200);
    drain();
    check("lap_800_m1", 64'(last_data[0]), 64'd255);
    check("lap_800_m0", 64'(last_data[1]), 64'h20);
    check("lap_800_m2", 64'(last_data[2]), 64'd255);

    send_lap(8'd50);
    drain();
    check("lap_m400_m1", 64'(last_data[0]), 64'd0);
    check("lap_m400_m0", 64'(last_data[1]), 64'h70);
    check("lap_m400_m2", 64'(last_data[2]), 64'd255);

    // Overflow in the 19-bit variant, then a clean window clears the flag.
    for (int k = 0; k < 3; k++) send_beat(8'd255, 10'd511, k == 0, k == 2);
    drain();
    check("ovf_a19", 64'(last_ovf[3]), 64'd1);
    check("ovf_a24", 64'(last_ovf[0]), 64'd0);
    send_beat(8'd3, 10'd5, 1'b1, 1'b0);
    send_beat(8'd4, 10'd6, 1'b0, 1'b1);
    drain();
    check("ovf_clear_a19", 64'(last_ovf[3]), 64'd0);

    // One-beat windows and the signedness matrix.
    send_beat(8'd3, 10'h3FE, 1'b1, 1'b1);
    drain();
    check("one_beat_m2", 64'(last_data[2]), 64'd6);
    send_beat(8'hFF, 10'd4, 1'b1, 1'b1);
    drain();
    check("signed_pix_m1", 64'(last_data[4]), 64'd0);
    check("unsigned_pix_m1", 64'(last_data[0]), 64'd255);

    // Backpressure: stall with input pending, then release with no bubbles.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_beat(8'($urandom), 10'($urandom), 1'b1, 1'b1);
    in_valid = 1'b1; din0 = 8'($urandom); din1 = 10'($urandom); in_first = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_ready", 64'(s_ready), 64'd0);
      check("stall_valid", 64'(s_valid), 64'd1);
      check("stall_data",  64'(s_data),  64'(exp_q[0].data[0]));
    end
    out_ready = 1'b1;
    f0 = n_fire;
    c0 = cyc;
    wait_accept();
    for (int k = 0; k < 4; k++) send_beat(8'($urandom), 10'($urandom), 1'b1, 1'b1);
    in_valid = 1'b0;
    for (int k = 0; k < 32 && exp_q.size() != 0; k++) tick();
    check("bp_fires",  64'(n_fire - f0), 64'd8);
    check("bp_cycles", 64'(cyc - c0),    64'd8);
    drain();

    // Reset with a stalled result and a partial window in flight.
    out_ready = 1'b0;
    send_beat(8'd9, 10'd7, 1'b1, 1'b1);
    send_beat(8'd200, 10'd300, 1'b1, 1'b0);
    send_beat(8'd150, 10'd250, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    check("pre_rst_valid", 64'(s_valid), 64'd1);
    ap_rst = 1'b1;
    model_reset();
    prev_valid = 1'b0;
    tick();
    check("midrst_valid", 64'(s_valid), 64'd0);
    check("midrst_ready", 64'(s_ready), 64'd1);
    ap_rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) send_beat(8'd10 + 8'(k), 10'd3, 1'b0, k == 2);
    drain();
    check("after_rst_m1", 64'(last_data[0]), 64'd99);

    // Randomized windows, bubbles, missing/mid-window firsts, random backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int   len;
      logic nofirst;
      len     = $urandom_range(1, 9);
      nofirst = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < len; k++) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; din0 = 8'($urandom); din1 = 10'($urandom);
          in_first = 1'($urandom); in_last = 1'($urandom);
          out_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
        send_beat(8'($urandom), 10'($urandom),
                  (k == 0 && !nofirst) || ($urandom_range(0, 15) == 0), k == len - 1);
      end
    end
    rand_rdy = 1'b0;
    drain();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
